// File: rtl/uart_baud_gen_if.sv
`default_nettype none
// ============================================================================
// uart_baud_gen_if : control/config inputs and tick outputs of uart_baud_gen
// Rev 1.0
// ============================================================================
interface uart_baud_gen_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned PH_W   = 4
) ();
  logic              en;
  logic              resync;
  logic              cfg_wr;
  logic [DIV_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_pending;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic [PH_W-1:0]   os_phase;

  modport master (
    output en, resync, cfg_wr, cfg_div_int, cfg_div_frac,
    input  cfg_pending, os_tick, bit_tick, mid_tick, os_phase
  );

  modport slave (
    input  en, resync, cfg_wr, cfg_div_int, cfg_div_frac,
    output cfg_pending, os_tick, bit_tick, mid_tick, os_phase
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// uart_baud_gen : fractional oversample/bit/mid-bit clock-enable generator
// Rev 1.0
// ============================================================================
module uart_baud_gen #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input wire            clk,
  input wire            rst_n,
  uart_baud_gen_if.slave bus
);
  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam longint unsigned c_def_div =
      (64'(CLK_HZ) << FRAC_W) / (64'(BAUD) * 64'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  c_def_int  = DIV_W'(c_def_div >> FRAC_W);
  localparam logic [FRAC_W-1:0] c_def_frac = FRAC_W'(c_def_div);
  localparam logic [PH_W-1:0]   c_ph_last  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]   c_ph_premid = PH_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              e_q, e_d;
  logic [PH_W-1:0]   os_phase_q, os_phase_d;
  logic              os_tick_q, os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
  logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
  logic [DIV_W-1:0]  active_int_q, active_int_d;
  logic [FRAC_W-1:0] active_frac_q, active_frac_d;
  logic              cfg_pending_q, cfg_pending_d;

  logic [DIV_W-1:0]  w_div_eff;
  logic              w_tick_due;
  logic              w_apply;
  logic [FRAC_W:0]   w_sum;

  always_comb begin
    cnt_d         = cnt_q;
    frac_acc_d    = frac_acc_q;
    e_d           = e_q;
    os_phase_d    = os_phase_q;
    os_tick_d     = 1'b0;
    bit_tick_d    = 1'b0;
    mid_tick_d    = 1'b0;
    shadow_int_d  = shadow_int_q;
    shadow_frac_d = shadow_frac_q;
    active_int_d  = active_int_q;
    active_frac_d = active_frac_q;
    cfg_pending_d = cfg_pending_q;

    // Divisors below 2 would make cnt compare against a wrapped value.
    w_div_eff  = (active_int_q < DIV_W'(2)) ? DIV_W'(2) : active_int_q;
    w_tick_due = bus.en && (cnt_q == (w_div_eff - DIV_W'(1) + DIV_W'(e_q)));
    w_sum      = {1'b0, frac_acc_q} + {1'b0, active_frac_q};
    w_apply    = cfg_pending_q && (!bus.en || bus.resync || w_tick_due);

    if (!bus.en || bus.resync) begin
      cnt_d      = '0;
      frac_acc_d = '0;
      e_d        = 1'b0;
      os_phase_d = '0;
    end else if (w_tick_due) begin
      cnt_d             = '0;
      {e_d, frac_acc_d} = w_sum;
      os_tick_d         = 1'b1;
      bit_tick_d        = (os_phase_q == c_ph_last);
      mid_tick_d        = (os_phase_q == c_ph_premid);
      os_phase_d        = (os_phase_q == c_ph_last) ? '0 : os_phase_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (w_apply) begin
      active_int_d  = shadow_int_q;
      active_frac_d = shadow_frac_q;
      cfg_pending_d = 1'b0;
    end

    // A write landing on an apply edge still leaves the new value pending.
    if (bus.cfg_wr) begin
      shadow_int_d  = bus.cfg_div_int;
      shadow_frac_d = bus.cfg_div_frac;
      cfg_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frac_acc_q    <= '0;
      e_q           <= 1'b0;
      os_phase_q    <= '0;
      os_tick_q     <= 1'b0;
      bit_tick_q    <= 1'b0;
      mid_tick_q    <= 1'b0;
      shadow_int_q  <= c_def_int;
      shadow_frac_q <= c_def_frac;
      active_int_q  <= c_def_int;
      active_frac_q <= c_def_frac;
      cfg_pending_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frac_acc_q    <= frac_acc_d;
      e_q           <= e_d;
      os_phase_q    <= os_phase_d;
      os_tick_q     <= os_tick_d;
      bit_tick_q    <= bit_tick_d;
      mid_tick_q    <= mid_tick_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      active_int_q  <= active_int_d;
      active_frac_q <= active_frac_d;
      cfg_pending_q <= cfg_pending_d;
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.mid_tick    = mid_tick_q;
  assign bus.os_phase    = os_phase_q;
  assign bus.cfg_pending = cfg_pending_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// tb_uart_baud_gen : directed vectors and corner sequences for uart_baud_gen
// Rev 1.0
// ============================================================================
module tb_uart_baud_gen;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4), .PH_W(4)) bus ();

  uart_baud_gen #(
    .CLK_HZ(25000000), .BAUD(9600), .OVERSAMPLE(16), .DIV_W(16), .FRAC_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int div_int;
    int div_frac;
    bit do_cfg;
    int n_ticks;
    int exp_first;
    int exp_span;
    int exp_bits;
    int exp_mids;
    int exp_first_bit;
    int exp_phase;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance edge by edge until os_tick is seen; returns edges consumed.
  task automatic wait_tick(output int edges, input int bound);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!bus.os_tick && edges < bound);
  endtask

  task automatic write_cfg(input int div_int, input int div_frac);
    bus.cfg_div_int  = DIV_W'(div_int);
    bus.cfg_div_frac = FRAC_W'(div_frac);
    bus.cfg_wr       = 1'b1;
    @(posedge clk); #1;
    bus.cfg_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int edges, ticks, bits, mids, first_bit, stray;
    bus.en = 1'b0;
    if (v.do_cfg) write_cfg(v.div_int, v.div_frac);
    @(posedge clk); #1;
    check($sformatf("v%0d_pending_clr", idx), bus.cfg_pending, 0);
    bus.en = 1'b1;
    wait_tick(edges, v.exp_first + 50);
    check($sformatf("v%0d_first_tick", idx), edges, v.exp_first);
    ticks = 0; edges = 0; bits = 0; mids = 0; first_bit = 0; stray = 0;
    while (ticks < v.n_ticks && edges < 2 * v.exp_span + 50) begin
      @(posedge clk); #1;
      edges++;
      if (bus.os_tick) begin
        ticks++;
        if (bus.bit_tick) begin
          bits++;
          if (first_bit == 0) first_bit = ticks + 1;
        end
        if (bus.mid_tick) mids++;
      end else if (bus.bit_tick || bus.mid_tick) begin
        stray++;
      end
    end
    check($sformatf("v%0d_span", idx), edges, v.exp_span);
    check($sformatf("v%0d_bit_count", idx), bits, v.exp_bits);
    check($sformatf("v%0d_mid_count", idx), mids, v.exp_mids);
    check($sformatf("v%0d_first_bit_idx", idx), first_bit, v.exp_first_bit);
    check($sformatf("v%0d_phase", idx), int'(bus.os_phase), v.exp_phase);
    check($sformatf("v%0d_stray_ticks", idx), stray, 0);
    bus.en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   e, total;

    n_cmp = 0;
    n_bad = 0;
    // {int, frac, cfg, n, first, span, bits, mids, first_bit_idx, phase}
    vecs[0] = '{162, 12, 1'b0,   16, 162, 2604,  1,  1, 16, 1};
    vecs[1] = '{  4,  0, 1'b1,   16,   4,   64,  1,  1, 16, 1};
    vecs[2] = '{  4,  8, 1'b1, 1000,   4, 4500, 62, 63, 16, 9};
    vecs[3] = '{  0,  0, 1'b1,    8,   2,   16,  0,  1,  0, 9};
    vecs[4] = '{  1, 15, 1'b1,   16,   2,   47,  1,  1, 16, 1};
    vecs[5] = '{ 10,  3, 1'b1,   16,  10,  163,  1,  1, 16, 1};
    vecs[6] = '{  3,  1, 1'b1,   16,   3,   49,  1,  1, 16, 1};

    rst_n            = 1'b0;
    bus.en           = 1'b0;
    bus.resync       = 1'b0;
    bus.cfg_wr       = 1'b0;
    bus.cfg_div_int  = '0;
    bus.cfg_div_frac = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_os_tick", bus.os_tick, 0);
    check("rst_bit_mid", {bus.bit_tick, bus.mid_tick}, 0);
    check("rst_phase", int'(bus.os_phase), 0);
    check("rst_pending", bus.cfg_pending, 0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Resync at phase 5 restarts period and phase.
    write_cfg(4, 0);
    @(posedge clk); #1;
    bus.en = 1'b1;
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
    end while (bus.os_phase != 4'd5 && e < 200);
    check("reach_phase5", int'(bus.os_phase), 5);
    bus.resync = 1'b1;
    @(posedge clk); #1;
    bus.resync = 1'b0;
    check("resync_no_tick", bus.os_tick, 0);
    check("resync_phase", int'(bus.os_phase), 0);
    wait_tick(e, 50);
    check("resync_next_tick", e, 4);

    // Resync on the edge a tick is due suppresses it.
    repeat (3) begin @(posedge clk); #1; end
    bus.resync = 1'b1;
    @(posedge clk); #1;
    bus.resync = 1'b0;
    check("resync_beats_tick", bus.os_tick, 0);
    check("resync_beats_phase", int'(bus.os_phase), 0);
    wait_tick(e, 50);
    check("resync2_next_tick", e, 4);

    // Mid-period reconfiguration waits for the next tick.
    @(posedge clk); #1;
    bus.cfg_div_int  = DIV_W'(10);
    bus.cfg_div_frac = '0;
    bus.cfg_wr       = 1'b1;
    @(posedge clk); #1;
    bus.cfg_wr = 1'b0;
    check("midcfg_pending_set", bus.cfg_pending, 1);
    wait_tick(e, 50);
    check("midcfg_old_period_end", e, 2);
    check("midcfg_pending_clr", bus.cfg_pending, 0);
    wait_tick(e, 50);
    check("midcfg_new_period", e, 10);

    // Back-to-back writes while disabled: second coincides with apply, last wins.
    bus.en = 1'b0;
    bus.cfg_div_int  = DIV_W'(7);
    bus.cfg_div_frac = '0;
    bus.cfg_wr       = 1'b1;
    @(posedge clk); #1;
    bus.cfg_div_int = DIV_W'(5);
    @(posedge clk); #1;
    bus.cfg_wr = 1'b0;
    check("b2b_pending_held", bus.cfg_pending, 1);
    @(posedge clk); #1;
    check("b2b_pending_clr", bus.cfg_pending, 0);
    bus.en = 1'b1;
    wait_tick(e, 50);
    check("b2b_last_wins", e, 5);

    // Async reset mid-period with a pending config.
    write_cfg(10, 0);
    check("arst_pending_before", bus.cfg_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pending", bus.cfg_pending, 0);
    check("arst_phase", int'(bus.os_phase), 0);
    check("arst_ticks", {bus.os_tick, bus.bit_tick, bus.mid_tick}, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    wait_tick(e, 300);
    check("arst_default_first", e, 162);
    total = 0;
    for (int k = 0; k < 16; k++) begin
      wait_tick(e, 400);
      total += e;
    end
    check("arst_default_span16", total, 2604);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
